pam4_tx: RTL and testbench

- PAM4 transmitter and channel-model source for the SERDES simulation chain; it feeds the receive-side DFE.
- Accepts bytes over a valid/ready handshake and serialises each byte into four 2-bit symbols, MSB pair first.
- Maps each symbol to a signed PAM4 level and applies a 2-tap pulse response (h0=1, h1=0.5).
- Emits one signed sample per cycle. A start-up PRBS7 training burst provides the ideal levels on train_data for equaliser training.

---
 rtl/pam4_pkg.sv | 46 ++++
 rtl/pam4_channel_fir.sv | 38 +++
 rtl/pam4_tx.sv | 140 ++++++++++++++
 tb/tb_pam4_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions: FSM states, level constants, symbol mapping and PRBS7 taps.
// Define PAM4_GRAY_EN for Gray-coded symbol mapping; binary mapping otherwise.
package pam4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } tx_state_t;

  localparam int DEFAULT_SEP     = 56;
  localparam int PAM4_LVL_INNER  = DEFAULT_SEP / 2;
  localparam int PAM4_LVL_OUTER  = DEFAULT_SEP / 2 + DEFAULT_SEP;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

  // Levels are +-sep/2 and +-(sep/2 + sep); the receiver slicer uses the same thresholds.
  function automatic int pam4_level(input logic [1:0] sym, input int sep);
    int inner;
    int outer;
    inner = sep / 2;
    outer = inner + sep;
`ifdef PAM4_GRAY_EN
    case (sym)
      2'b00:   pam4_level = -outer;
      2'b01:   pam4_level = -inner;
      2'b11:   pam4_level = inner;
      default: pam4_level = outer;
    endcase
`else
    case (sym)
      2'b00:   pam4_level = -outer;
      2'b01:   pam4_level = -inner;
      2'b10:   pam4_level = inner;
      default: pam4_level = outer;
    endcase
`endif
  endfunction

endpackage

// File: rtl/pam4_channel_fir.sv
// Two-tap channel pulse response y = x + x_prev/2 with saturation to the sample width.
module pam4_channel_fir #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic signed [W-1:0] x_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic signed [W-1:0] y_o
);

  logic signed [W-1:0] x_prev_q;
  logic signed [W-1:0] half;
  logic        [W:0]   sum;

  assign half = x_prev_q >>> 1;
  assign sum  = {x_i[W-1], x_i} + {half[W-1], half};

  always_comb begin
    y_o = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      y_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // A state change starts a fresh symbol stream, so the ISI tap is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_prev_q <= '0;
    end else if (clear_i) begin
      x_prev_q <= '0;
    end else if (valid_i) begin
      x_prev_q <= x_i;
    end
  end

endmodule

// File: rtl/pam4_tx.sv
// PAM4 transmitter with PRBS7 training bursts and a 2-tap channel model on the output.
// Symbol mapping is Gray when PAM4_GRAY_EN is defined, binary otherwise.
module pam4_tx
  import pam4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = DEFAULT_SEP,
  parameter int TRAIN_LENGTH      = 64
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [7:0]                          data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic                                train_start,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] train_data,
  output logic                                train_data_valid,
  output logic                                tx_busy
);

  localparam int W     = SIGNAL_RESOLUTION;
  localparam int CNT_W = (TRAIN_LENGTH > 1) ? $clog2(TRAIN_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(TRAIN_LENGTH - 1);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [7:0]        buf_q, buf_d;
  logic [2:0]        left_q, left_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic              pending_q, pending_d;

  logic              accept;
  logic              sym_valid;
  logic [1:0]        sym;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic              fir_clear;

  logic signed [W-1:0] sig_q, train_q;
  logic              sig_valid_q, train_valid_q;

  // Ready while the last buffered symbol issues, so consecutive bytes leave no gap.
  assign data_in_ready = (state_q == DATA) && !pending_q && (left_q <= 3'd1);
  assign accept        = data_in_valid && data_in_ready;
  assign tx_busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    buf_d     = buf_q;
    left_d    = left_q;
    lfsr_d    = lfsr_q;
    pending_d = pending_q;
    sym       = 2'b00;
    sym_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (train_start) state_d = TRAIN;
      end
      TRAIN: begin
        sym       = lfsr_q[6:5];
        sym_valid = 1'b1;
        lfsr_d    = prbs7_step(prbs7_step(lfsr_q));
        if (sym_cnt_q == LAST_SYM) begin
          sym_cnt_d = '0;
          state_d   = DATA;
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (train_start) pending_d = 1'b1;
        if (left_q != 3'd0) begin
          sym       = buf_q[7:6];
          sym_valid = 1'b1;
          buf_d     = {buf_q[5:0], 2'b00};
          left_d    = left_q - 3'd1;
        end
        if (accept) begin
          buf_d  = data_in;
          left_d = 3'd4;
        end
        if (pending_q && (left_q <= 3'd1)) begin
          state_d   = TRAIN;
          pending_d = 1'b0;
          left_d    = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x         = W'(pam4_level(sym, SYMBOL_SEPERATION));
  assign fir_clear = (state_d != state_q);

  pam4_channel_fir #(
    .W(W)
  ) u_fir (
    .clk     (clk),
    .rstn    (rstn),
    .x_i     (x),
    .valid_i (sym_valid),
    .clear_i (fir_clear),
    .y_o     (y)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sym_cnt_q     <= '0;
      buf_q         <= '0;
      left_q        <= '0;
      lfsr_q        <= PRBS7_SEED;
      pending_q     <= 1'b0;
      sig_q         <= '0;
      sig_valid_q   <= 1'b0;
      train_q       <= '0;
      train_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      buf_q         <= buf_d;
      left_q        <= left_d;
      lfsr_q        <= lfsr_d;
      pending_q     <= pending_d;
      sig_q         <= sym_valid ? y : '0;
      sig_valid_q   <= sym_valid;
      train_q       <= (state_q == TRAIN) ? x : '0;
      train_valid_q <= (state_q == TRAIN);
    end
  end

  assign signal_out       = sig_q;
  assign signal_out_valid = sig_valid_q;
  assign train_data       = train_q;
  assign train_data_valid = train_valid_q;

endmodule

// File: tb/tb_pam4_tx.sv
// Scoreboard bench for pam4_tx: random bytes, training bursts, retrain and reset mid-byte.
module tb_pam4_tx;

  localparam int W   = 8;
  localparam int SEP = 56;
  localparam int TL  = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic data_in_valid = 1'b0;
  logic train_start = 1'b0;
  logic data_in_ready;
  logic signed [W-1:0] signal_out;
  logic signed [W-1:0] train_data;
  logic signal_out_valid, train_data_valid, tx_busy;

  always #5 clk = ~clk;

  pam4_tx #(
    .SIGNAL_RESOLUTION (W),
    .SYMBOL_SEPERATION (SEP),
    .TRAIN_LENGTH      (TL)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_ready    (data_in_ready),
    .train_start      (train_start),
    .signal_out       (signal_out),
    .signal_out_valid (signal_out_valid),
    .train_data       (train_data),
    .train_data_valid (train_data_valid),
    .tx_busy          (tx_busy)
  );

  typedef struct {
    int sig;
    bit tv;
    int td;
  } exp_t;

  exp_t sb[$];
  bit   prbs[$];
  int   xprev;
  int   checks = 0;
  int   errors = 0;
  int   train_pulses = 0;
  int   run_len = 0;
  int   max_run = 0;

  // Ideal levels are evenly spaced SEP apart starting at -(SEP/2 + SEP).
  function automatic int level(input bit [1:0] s);
    int idx;
`ifdef PAM4_GRAY_EN
    idx = {s[1], s[1] ^ s[0]};
`else
    idx = s;
`endif
    return -(SEP / 2 + SEP) + idx * SEP;
  endfunction

  function automatic int chan(input int x);
    int y;
    int lo;
    int hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    y = x + (xprev >>> 1);
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    xprev = x;
    return y;
  endfunction

  // PRBS7 as a bit stream: s[n+7] = s[n] ^ s[n+1].
  function automatic bit prbs_bit();
    bit nb;
    nb = prbs[0] ^ prbs[1];
    prbs.push_back(nb);
    return prbs.pop_front();
  endfunction

  function automatic void push_sym(input bit [1:0] s, input bit tr);
    exp_t e;
    int x;
    x = level(s);
    e.sig = chan(x);
    e.tv = tr;
    e.td = tr ? x : 0;
    sb.push_back(e);
  endfunction

  function automatic void push_train();
    bit b1;
    bit b0;
    xprev = 0;
    for (int k = 0; k < TL; k++) begin
      b1 = prbs_bit();
      b0 = prbs_bit();
      push_sym({b1, b0}, 1'b1);
    end
    xprev = 0;
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) push_sym(b[2*k+1 -: 2], 1'b0);
  endfunction

  function automatic void reset_model();
    sb.delete();
    prbs.delete();
    for (int k = 0; k < 7; k++) prbs.push_back(1'b1);
    xprev = 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented sample is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (train_data_valid) train_pulses++;
      if (signal_out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got signal_out=%0d with no expected sample", int'(signal_out));
        end else begin
          e = sb.pop_front();
          if (int'(signal_out) != e.sig || train_data_valid != e.tv || int'(train_data) != e.td) begin
            errors++;
            $display("FAIL sample: got sig=%0d tv=%0d td=%0d expected sig=%0d tv=%0d td=%0d",
                     int'(signal_out), train_data_valid, int'(train_data), e.sig, e.tv, e.td);
          end else begin
            $display("sample sig=%0d tv=%0d td=%0d ok", int'(signal_out), train_data_valid, int'(train_data));
          end
        end
      end else begin
        run_len = 0;
        if (train_data_valid) begin
          checks++;
          errors++;
          $display("FAIL train_valid_alone: got train_data_valid=1 expected 0");
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    int budget;
    budget = 0;
    data_in = b;
    data_in_valid = 1'b1;
    while (!data_in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 300) begin
        chk("ready_timeout", 0, 1);
        data_in_valid = 1'b0;
        return;
      end
    end
    push_byte(b);
    @(negedge clk);
    if (!keep_valid) data_in_valid = 1'b0;
  endtask

  task automatic pulse_train();
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_sig"}, int'(signal_out), 0);
    chk({name, "_sig_valid"}, int'(signal_out_valid), 0);
    chk({name, "_train"}, int'(train_data), 0);
    chk({name, "_train_valid"}, int'(train_data_valid), 0);
    chk({name, "_ready"}, int'(data_in_ready), 0);
    chk({name, "_busy"}, int'(tx_busy), 0);
  endtask

  initial begin
    bit kv;
    reset_model();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(tx_busy), 0);
    chk("idle_ready", int'(data_in_ready), 0);

    push_train();
    train_pulses = 0;
    pulse_train();
    chk("train_busy", int'(tx_busy), 1);
    chk("train_ready", int'(data_in_ready), 0);
    wait_drain("train_drain");
    @(negedge clk);
    chk("train_pulses", train_pulses, TL);
    chk("data_busy", int'(tx_busy), 1);
    chk("data_ready", int'(data_in_ready), 1);

    send_byte(8'hB4, 1'b0);
    wait_drain("b4_drain");
    chk("b4_ready_after", int'(data_in_ready), 1);

    @(negedge clk);
    max_run = 0;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b0);
    wait_drain("aa_drain");
    @(negedge clk);
    chk("aa_no_bubble_run", max_run, 8);

    for (int i = 0; i < 40; i++) begin
      kv = (i != 39) && ($urandom_range(0, 1) == 1);
      send_byte(8'($urandom), kv);
      if (!kv) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rand_drain");

    // Retrain requested while the second symbol of a byte is issuing.
    send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    push_train();
    pulse_train();
    chk("pending_ready_a", int'(data_in_ready), 0);
    @(negedge clk);
    chk("pending_ready_b", int'(data_in_ready), 0);
    repeat (5) @(negedge clk);
    pulse_train();
    wait_drain("retrain_drain");
    @(negedge clk);
    chk("retrain_ready", int'(data_in_ready), 1);
    send_byte(8'($urandom), 1'b0);
    wait_drain("post_retrain_drain");

    // Asynchronous reset in the middle of a byte.
    send_byte(8'h5C, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    reset_model();
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_busy", int'(tx_busy), 0);
    chk("post_reset_valid", int'(signal_out_valid), 0);

    push_train();
    pulse_train();
    wait_drain("reseed_train_drain");
    @(negedge clk);
    send_byte(8'($urandom), 1'b0);
    wait_drain("final_drain");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
